fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the five-stage MIPS core. It owns the PC and issues requests to instruction memory over a req/ready handshake. It presents pc, pc_4 and instruction to the decode stage, which sits directly downstream. It also absorbs decode stalls (keep), delayed-branch redirects and pipeline flushes, with a one-entry hold buffer so that no fetched word is ever lost.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- keep  in  1  decode stall: IF/ID must hold its contents.
- redirect  in  1  branch/jump resolved taken in decode; meaningful only when keep=0.
- redirect_pc  in  32  target address for redirect.
- flush  in  1  kill all younger work and restart at flush_pc (exception/eret); has priority over everything else.
- flush_pc  in  32  restart address.
- imem_req  out  1  fetch request outstanding.
- imem_addr  out  32  word address of the request; stable while imem_req=1 and imem_ready=0.
- imem_ready  in  1  data valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  fetched instruction, valid when imem_ready=1.
- pc  out  32  IF/ID: PC of the presented instruction.
- pc_4  out  32  IF/ID: pc+4.
- instruction  out  32  IF/ID: instruction word; 32'h0 (NOP) when it is a bubble.
- valid  out  1  IF/ID holds a real instruction.

## Operation
- Registers:
  - fetch_pc
  - req_addr
  - hold_buf and hold_pc
  - pend_valid and pend_pc (latched redirect)
  - IF/ID (pc, pc_4, instruction, valid)
  - 2-bit state
- States:
  - FETCH: imem_req=1, imem_addr=fetch_pc.
  - HOLD: word captured while stalled; imem_req=0.
  - DISCARD: request orphaned by a flush; imem_req=1, imem_addr=req_addr.
- Next fetch address (nxt): redirect_pc if redirect&&!keep this cycle; else pend_pc if pend_valid; else fetch_pc+4 (mod 2^32, wraps silently). Consuming pend clears pend_valid.
- Delayed branch: the word fetched while the branch sits in decode is the delay slot. It is never squashed. The redirect only changes the address fetched after it.
- FETCH:
  - ready && !keep: IF/ID <= {fetch_pc, fetch_pc+4, rdata, 1}; fetch_pc <= nxt; stay in FETCH.
  - ready && keep: hold_buf/hold_pc <= rdata/fetch_pc; IF/ID unchanged; go to HOLD.
  - !ready && !keep: IF/ID <= bubble {pc, pc_4 unchanged, 0, 0}.
  - !ready && keep: IF/ID unchanged.
- HOLD:
  - !keep: IF/ID <= {hold_pc, hold_pc+4, hold_buf, 1}; fetch_pc <= nxt; go to FETCH.
- redirect && !keep without a completed word that cycle: pend_valid <= 1, pend_pc <= redirect_pc.
- A second redirect while pend_valid=1 overwrites pend_pc.
- flush, any state:
  - IF/ID <= bubble, pend_valid <= 0, fetch_pc <= flush_pc.
  - FETCH && !ready: req_addr <= fetch_pc; go to DISCARD.
  - Otherwise: go to FETCH.
  - Any word returned in the flush cycle is dropped.
- DISCARD: on ready, drop the data and go to FETCH. Flush in DISCARD only updates fetch_pc.
- Simultaneous keep and flush: flush wins; the bubble is written despite keep.

## Timing
- Reset values:
  - pc=0, pc_4=0, instruction=0, valid=0
  - fetch_pc=RESET_PC, pend_valid=0, state=FETCH
  - imem_req=1 from the first cycle after reset release
- Zero-wait memory: one instruction per cycle. The word requested in cycle n appears on the IF/ID outputs in cycle n+1.
- N-wait memory: N bubbles are inserted per fetch.
- Redirect latency: with zero-wait memory, imem_addr=redirect_pc in the cycle after the delay slot is accepted.
- Flush latency: with no orphaned request, imem_addr=flush_pc in the next cycle. Otherwise it appears one cycle after the orphan's ready.
- Reset mid-request abandons the request; the memory model must also drop it on reset.

## Structure
- Shared package:
  - NOP word 32'h0
  - state encodings FETCH=2'b00, HOLD=2'b01, DISCARD=2'b10
  - RESET_PC default
- No sub-module is needed. The IF/ID register stays inside this block so that the decode stage's keep semantics are owned in one place.

## Test plan
- Zero-wait memory, no stalls, reset at RESET_PC=0: imem_addr sequence 0,4,8,C; instruction equals the memory word one cycle later; valid=1 continuously.
- keep=1 for 3 cycles while ready: imem_req drops after capture; IF/ID is held; on release the held word at PC 0x8 is presented and the next fetch is 0xC, with no duplicate or lost word.
- Branch at 0x10 with redirect_pc=0x40: delay slot 0x14 is presented with valid=1; the next imem_addr is 0x40; 0x18 is never requested.
- Redirect while delay-slot fetch 0x14 is waiting 2 cycles: pend latched; after 0x14 returns, imem_addr=0x40.
- flush (flush_pc=0x80) during a 3-wait fetch of 0x20: IF/ID bubble; imem_addr stays 0x20 until ready; data dropped; then imem_addr=0x80.
- flush together with keep=1: IF/ID becomes the bubble (instruction=0, valid=0). Async reset mid-HOLD: all outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_stage_pkg;

   localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_FETCH   = 2'b00,
      ST_HOLD    = 2'b01,
      ST_DISCARD = 2'b10
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch with IF/ID register, hold buffer,
// delayed-branch redirect and flush handling
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        keep,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc_4,
   output logic [31:0] instruction,
   output logic        valid
);

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  req_addr;
   logic [31:0]  hold_buf;
   logic [31:0]  hold_pc;
   logic [31:0]  pend_pc;
   logic         pend_valid;
   logic         take_redirect;
   logic [31:0]  nxt;

   assign take_redirect = redirect && !keep;

   // A live redirect beats a latched one; the latched one beats sequential fetch.
   always_comb begin
      nxt = fetch_pc + 32'd4;
      if (take_redirect)
         nxt = redirect_pc;
      else if (pend_valid)
         nxt = pend_pc;
   end

   assign imem_req  = (state != ST_HOLD);
   assign imem_addr = (state == ST_DISCARD) ? req_addr : fetch_pc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_FETCH;
         fetch_pc    <= RESET_PC;
         req_addr    <= '0;
         hold_buf    <= '0;
         hold_pc     <= '0;
         pend_pc     <= '0;
         pend_valid  <= 1'b0;
         pc          <= '0;
         pc_4        <= '0;
         instruction <= NOP_WORD;
         valid       <= 1'b0;
      end else if (flush) begin
         instruction <= NOP_WORD;
         valid       <= 1'b0;
         pend_valid  <= 1'b0;
         fetch_pc    <= flush_pc;
         case (state)
            ST_FETCH: begin
               // An unanswered request must still be drained before refetching.
               if (!imem_ready) begin
                  req_addr <= fetch_pc;
                  state    <= ST_DISCARD;
               end
            end
            ST_DISCARD: begin
               if (imem_ready)
                  state <= ST_FETCH;
            end
            default: state <= ST_FETCH;
         endcase
      end else begin
         case (state)
            ST_FETCH: begin
               if (imem_ready) begin
                  if (!keep) begin
                     pc          <= fetch_pc;
                     pc_4        <= fetch_pc + 32'd4;
                     instruction <= imem_rdata;
                     valid       <= 1'b1;
                     fetch_pc    <= nxt;
                     pend_valid  <= 1'b0;
                  end else begin
                     hold_buf <= imem_rdata;
                     hold_pc  <= fetch_pc;
                     state    <= ST_HOLD;
                  end
               end else if (!keep) begin
                  instruction <= NOP_WORD;
                  valid       <= 1'b0;
                  if (redirect) begin
                     pend_valid <= 1'b1;
                     pend_pc    <= redirect_pc;
                  end
               end
            end
            ST_HOLD: begin
               if (!keep) begin
                  pc          <= hold_pc;
                  pc_4        <= hold_pc + 32'd4;
                  instruction <= hold_buf;
                  valid       <= 1'b1;
                  fetch_pc    <= nxt;
                  pend_valid  <= 1'b0;
                  state       <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (imem_ready)
                  state <= ST_FETCH;
               if (take_redirect) begin
                  pend_valid <= 1'b1;
                  pend_pc    <= redirect_pc;
               end
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed scoreboard bench for fetch_stage
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        keep = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        flush = 1'b0;
   logic [31:0] flush_pc = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_4;
   logic [31:0] instruction;
   logic        valid;

   int tests = 0;
   int fails = 0;
   int wait_n = 0;
   int wcnt;
   int n18 = 0;
   int n18_snap;
   logic upd;
   logic [31:0] exp_q[$];

   fetch_stage dut (
      .clk(clk), .reset(reset), .keep(keep), .redirect(redirect),
      .redirect_pc(redirect_pc), .flush(flush), .flush_pc(flush_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .pc(pc), .pc_4(pc_4),
      .instruction(instruction), .valid(valid)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ (a << 16) ^ 32'h3C00_0001;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory model: N wait cycles per request, request dropped on reset.
   always @(posedge clk or posedge reset) begin
      if (reset)
         wcnt <= 0;
      else if (imem_req && imem_ready)
         wcnt <= 0;
      else if (imem_req)
         wcnt <= wcnt + 1;
   end
   assign imem_ready = imem_req && !reset && (wcnt >= wait_n);
   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (!reset && imem_req && imem_ready && imem_addr == 32'h18)
         n18 <= n18 + 1;
   end

   // IF/ID may only change on an edge where decode was not stalled.
   always @(posedge clk or posedge reset) begin
      if (reset)
         upd <= 1'b0;
      else
         upd <= !keep && !flush;
   end

   always @(negedge clk) begin
      logic [31:0] e;
      if (!reset && upd && valid) begin
         check("sb_expected_present", {31'd0, exp_q.size() > 0}, 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_pc", pc, e);
            check("sb_pc_4", pc_4, e + 32'd4);
            check("sb_instruction", instruction, mem_word(e));
         end
      end
   end

   task automatic do_reset();
      reset    = 1'b1;
      keep     = 1'b0;
      redirect = 1'b0;
      flush    = 1'b0;
      wait_n   = 0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_seq(input logic [31:0] first, input int n);
      for (int i = 0; i < n; i++)
         exp_q.push_back(first + 32'(4 * i));
   endtask

   initial begin
      // Reset values
      #1;
      check("rst_pc", pc, 32'h0);
      check("rst_pc_4", pc_4, 32'h0);
      check("rst_instruction", instruction, 32'h0);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_imem_addr", imem_addr, 32'h0);

      // Zero-wait streaming
      do_reset();
      push_seq(32'h0, 4);
      for (int i = 0; i < 4; i++) begin
         check("stream_req", {31'd0, imem_req}, 32'd1);
         check("stream_addr", imem_addr, 32'(4 * i));
         @(negedge clk);
         check("stream_valid", {31'd0, valid}, 32'd1);
      end
      #2 check("stream_drained", exp_q.size(), 32'd0);

      // keep for 3 cycles with memory ready, then async reset in HOLD
      do_reset();
      push_seq(32'h0, 4);
      repeat (2) @(negedge clk);
      check("keep_addr_before", imem_addr, 32'h8);
      keep = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("keep_req_low", {31'd0, imem_req}, 32'd0);
         check("keep_ifid_held", pc, 32'h4);
      end
      keep = 1'b0;
      @(negedge clk);
      check("keep_release_pc", pc, 32'h8);
      check("keep_release_next", imem_addr, 32'hC);
      @(negedge clk);
      keep = 1'b1;
      @(negedge clk);
      check("hold2_req_low", {31'd0, imem_req}, 32'd0);
      #2 check("keep_drained", exp_q.size(), 32'd0);
      reset = 1'b1;
      #1;
      check("async_rst_pc", pc, 32'h0);
      check("async_rst_pc_4", pc_4, 32'h0);
      check("async_rst_instr", instruction, 32'h0);
      check("async_rst_valid", {31'd0, valid}, 32'd0);
      check("async_rst_req", {31'd0, imem_req}, 32'd1);
      check("async_rst_addr", imem_addr, 32'h0);

      // Branch at 0x10, zero-wait: delay slot kept, 0x18 never fetched
      do_reset();
      push_seq(32'h0, 6);
      push_seq(32'h40, 2);
      n18_snap = n18;
      repeat (5) @(negedge clk);
      check("br_pc", pc, 32'h10);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect = 1'b0;
      check("br_slot_pc", pc, 32'h14);
      check("br_slot_valid", {31'd0, valid}, 32'd1);
      check("br_target_addr", imem_addr, 32'h40);
      repeat (2) @(negedge clk);
      #2 check("br_drained", exp_q.size(), 32'd0);
      check("br_no_0x18", n18, n18_snap);

      // Redirect while the delay slot waits 2 cycles
      do_reset();
      push_seq(32'h0, 6);
      push_seq(32'h40, 1);
      repeat (5) @(negedge clk);
      wait_n      = 2;
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      @(negedge clk);
      redirect = 1'b0;
      check("pend_bubble1", {31'd0, valid}, 32'd0);
      check("pend_addr1", imem_addr, 32'h14);
      @(negedge clk);
      check("pend_bubble2", {31'd0, valid}, 32'd0);
      check("pend_addr2", imem_addr, 32'h14);
      @(negedge clk);
      check("pend_slot_pc", pc, 32'h14);
      check("pend_target_addr", imem_addr, 32'h40);
      wait_n = 0;
      @(negedge clk);
      #2 check("pend_drained", exp_q.size(), 32'd0);

      // Flush during a 3-wait fetch of 0x20
      do_reset();
      push_seq(32'h0, 8);
      push_seq(32'h80, 1);
      repeat (8) @(negedge clk);
      check("fl_addr_0x20", imem_addr, 32'h20);
      wait_n = 3;
      @(negedge clk);
      flush    = 1'b1;
      flush_pc = 32'h80;
      @(negedge clk);
      flush = 1'b0;
      check("fl_orphan_addr1", imem_addr, 32'h20);
      check("fl_bubble_valid", {31'd0, valid}, 32'd0);
      check("fl_bubble_instr", instruction, 32'h0);
      @(negedge clk);
      check("fl_orphan_addr2", imem_addr, 32'h20);
      @(negedge clk);
      check("fl_restart_addr", imem_addr, 32'h80);
      check("fl_dropped_valid", {31'd0, valid}, 32'd0);
      wait_n = 0;
      @(negedge clk);
      #2 check("fl_drained", exp_q.size(), 32'd0);

      // Flush together with keep
      do_reset();
      push_seq(32'h0, 3);
      push_seq(32'h80, 1);
      repeat (3) @(negedge clk);
      keep     = 1'b1;
      flush    = 1'b1;
      flush_pc = 32'h80;
      @(negedge clk);
      keep  = 1'b0;
      flush = 1'b0;
      check("fk_valid", {31'd0, valid}, 32'd0);
      check("fk_instr", instruction, 32'h0);
      check("fk_addr", imem_addr, 32'h80);
      @(negedge clk);
      #2 check("fk_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
